// File: rtl/nz_dispatch_5.sv
// Sparse PE producer: latches a feature/weight vector pair and issues the
// feature non-zero addresses in groups of up to MAC_DIM lanes per cycle.
module nz_dispatch_5 #(
  parameter int MAC_DIM    = 5,
  parameter int FEAT_WIDTH = 8,
  parameter int WGT_WIDTH  = 8,
  parameter int SPAD_WIDTH = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [FEAT_WIDTH*SPAD_WIDTH-1:0] feature_in,
  input  logic [WGT_WIDTH*SPAD_WIDTH-1:0]  weight_in,
  output logic [FEAT_WIDTH*SPAD_WIDTH-1:0] feature_out,
  output logic [WGT_WIDTH*SPAD_WIDTH-1:0]  weight_out,
  output logic [ADDR_WIDTH*MAC_DIM-1:0]    non_zero_add_out,
  output logic [2:0]                       non_zero_num,
  output logic                             acc,
  output logic                             done,
  output logic                             issue_vd,
  output logic                             busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t                           state_q;
  logic [FEAT_WIDTH*SPAD_WIDTH-1:0] feat_q;
  logic [WGT_WIDTH*SPAD_WIDTH-1:0]  wgt_q;
  logic [SPAD_WIDTH-1:0]            mask_q;
  logic                             first_q;
  logic [ADDR_WIDTH*MAC_DIM-1:0]    addr_q;
  logic [2:0]                       num_q;
  logic                             acc_q;
  logic                             done_q;
  logic                             vd_q;

  logic [SPAD_WIDTH-1:0]            load_mask_d;
  logic [SPAD_WIDTH-1:0]            mask_d;
  logic [ADDR_WIDTH-1:0]            lane_addr_s [MAC_DIM];
  logic [ADDR_WIDTH*MAC_DIM-1:0]    addr_d;
  logic [2:0]                       lane_cnt_s;
  logic [2:0]                       num_d;
  logic                             done_d;

  // Non-zero mask of the incoming feature vector
  always_comb begin
    load_mask_d = '0;
    for (int i = 0; i < SPAD_WIDTH; i++) begin
      load_mask_d[i] = (feature_in[i*FEAT_WIDTH +: FEAT_WIDTH] != '0);
    end
  end

  // Pick the lowest set mask bits for the next group; an empty mask yields
  // a single lane at address 0 so an all-zero vector still completes.
  always_comb begin
    mask_d     = mask_q;
    lane_cnt_s = 3'd0;
    addr_d     = '0;
    for (int j = 0; j < MAC_DIM; j++) begin
      lane_addr_s[j] = '0;
    end
    for (int i = 0; i < SPAD_WIDTH; i++) begin
      if (mask_q[i] && (lane_cnt_s < 3'(MAC_DIM))) begin
        lane_addr_s[lane_cnt_s] = ADDR_WIDTH'(i);
        mask_d[i]               = 1'b0;
        lane_cnt_s              = lane_cnt_s + 3'd1;
      end else begin
        lane_cnt_s = lane_cnt_s;
      end
    end
    for (int j = 0; j < MAC_DIM; j++) begin
      addr_d[j*ADDR_WIDTH +: ADDR_WIDTH] = lane_addr_s[j];
    end
    num_d  = (lane_cnt_s == 3'd0) ? 3'd0 : (lane_cnt_s - 3'd1);
    done_d = (mask_d == '0);
  end

  // Dispatch FSM with registered group outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      feat_q  <= '0;
      wgt_q   <= '0;
      mask_q  <= '0;
      first_q <= 1'b0;
      addr_q  <= '0;
      num_q   <= 3'd0;
      acc_q   <= 1'b0;
      done_q  <= 1'b0;
      vd_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          vd_q <= 1'b0;
          if (in_valid) begin
            feat_q  <= feature_in;
            wgt_q   <= weight_in;
            mask_q  <= load_mask_d;
            first_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          addr_q  <= addr_d;
          num_q   <= num_d;
          acc_q   <= ~first_q;
          done_q  <= done_d;
          vd_q    <= 1'b1;
          first_q <= 1'b0;
          mask_q  <= mask_d;
          if (done_d) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          vd_q    <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready         = (state_q == IDLE);
  assign busy             = (state_q == ISSUE);
  assign feature_out      = feat_q;
  assign weight_out       = wgt_q;
  assign non_zero_add_out = addr_q;
  assign non_zero_num     = num_q;
  assign acc              = acc_q;
  assign done             = done_q;
  assign issue_vd         = vd_q;

endmodule

// File: tb/tb_nz_dispatch_5.sv
// Scoreboard bench for nz_dispatch_5: expected groups are queued at each
// handshake and compared, including their cycle, as the DUT presents them.
module tb_nz_dispatch_5;
  localparam int FW = 8 * 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] feature_in;
  logic [FW-1:0] weight_in;
  logic [FW-1:0] feature_out;
  logic [FW-1:0] weight_out;
  logic [29:0]   non_zero_add_out;
  logic [2:0]    non_zero_num;
  logic          acc;
  logic          done;
  logic          issue_vd;
  logic          busy;

  nz_dispatch_5 dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .feature_in(feature_in), .weight_in(weight_in),
    .feature_out(feature_out), .weight_out(weight_out),
    .non_zero_add_out(non_zero_add_out), .non_zero_num(non_zero_num),
    .acc(acc), .done(done), .issue_vd(issue_vd), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0]   addr;
    logic [2:0]    num;
    logic          acc;
    logic          done;
    int            cyc;
    logic [FW-1:0] feat;
    logic [FW-1:0] wgt;
  } grp_t;

  grp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Monitor: every presented group must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset && issue_vd) begin
      if (sb.size() == 0) begin
        chk("spurious_group", FW'(issue_vd), FW'(0));
      end else begin
        grp_t e;
        e = sb.pop_front();
        chk("addr", FW'(non_zero_add_out), FW'(e.addr));
        chk("num", FW'(non_zero_num), FW'(e.num));
        chk("acc", FW'(acc), FW'(e.acc));
        chk("done", FW'(done), FW'(e.done));
        chk("cycle", FW'(cyc), FW'(e.cyc));
        chk("feature_out", feature_out, e.feat);
        chk("weight_out", weight_out, e.wgt);
        chk("in_ready_vs_done", FW'(in_ready), FW'(e.done));
      end
    end
  end

  // Reference model: split the non-zero indices into groups of five
  task automatic push_model(input logic [FW-1:0] f, input logic [FW-1:0] w, input int first_cyc);
    int idx[$];
    int g;
    grp_t e;
    for (int i = 0; i < 64; i++) begin
      logic [7:0] el;
      el = f[i*8 +: 8];
      if (el != 8'd0) idx.push_back(i);
    end
    g = 0;
    do begin
      e.addr = '0;
      e.num  = 3'd0;
      for (int l = 0; l < 5; l++) begin
        if (idx.size() > 0) begin
          e.addr[l*6 +: 6] = 6'(idx.pop_front());
          e.num = 3'(l);
        end
      end
      e.acc  = (g != 0);
      e.done = (idx.size() == 0);
      e.cyc  = first_cyc + g;
      e.feat = f;
      e.wgt  = w;
      sb.push_back(e);
      g++;
    end while (idx.size() > 0);
  endtask

  task automatic send_vec(input logic [FW-1:0] f, input logic [FW-1:0] w);
    bit ok;
    ok = 1'b0;
    feature_in = f;
    weight_in  = w;
    in_valid   = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) push_model(f, w, cyc + 2);
    else chk("accept_timeout", FW'(in_ready), FW'(1));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain_and_idle(input logic [FW-1:0] f);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_timeout", FW'(sb.size()), FW'(0));
    tick();
    chk("idle_vd", FW'(issue_vd), FW'(0));
    chk("idle_busy", FW'(busy), FW'(0));
    chk("idle_ready", FW'(in_ready), FW'(1));
    chk("hold_feature", feature_out, f);
  endtask

  function automatic logic [FW-1:0] vec_at(input int ids[$], input int seed);
    logic [FW-1:0] v;
    v = '0;
    foreach (ids[k]) v[ids[k]*8 +: 8] = 8'(ids[k] + seed) | 8'h01;
    return v;
  endfunction

  function automatic logic [FW-1:0] rnd_vec(input int pct_nz);
    logic [FW-1:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(99, 0) < pct_nz) v[i*8 +: 8] = 8'($urandom_range(255, 1));
    end
    return v;
  endfunction

  initial begin
    logic [FW-1:0] f1, f2, w1, zero_v;
    int ids[$];
    zero_v     = '0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    feature_in = '0;
    weight_in  = '0;
    tick();
    tick();
    chk("rst_ready", FW'(in_ready), FW'(1));
    chk("rst_vd", FW'(issue_vd), FW'(0));
    chk("rst_busy", FW'(busy), FW'(0));
    chk("rst_addr", FW'(non_zero_add_out), FW'(0));
    chk("rst_num_acc_done", FW'({non_zero_num, acc, done}), FW'(0));
    chk("rst_feature", feature_out, zero_v);
    chk("rst_weight", weight_out, zero_v);
    reset = 1'b0;
    tick();

    ids = '{3, 7, 8, 20, 21, 40, 63};
    f1 = vec_at(ids, 1);
    w1 = rnd_vec(100);
    send_vec(f1, w1);
    drain_and_idle(f1);

    ids = '{0, 1, 2, 62, 63};
    f1 = vec_at(ids, 5);
    send_vec(f1, rnd_vec(100));
    drain_and_idle(f1);

    send_vec(zero_v, rnd_vec(100));
    drain_and_idle(zero_v);

    // Back-to-back pair: second is accepted while the first's done group shows
    ids = '{1, 2, 3, 4, 5, 6, 30};
    f1 = vec_at(ids, 2);
    ids = '{9, 50};
    f2 = vec_at(ids, 3);
    send_vec(f1, rnd_vec(100));
    send_vec(f2, rnd_vec(100));
    drain_and_idle(f2);

    for (int r = 0; r < 4; r++) begin
      f1 = rnd_vec(10 + r * 25);
      send_vec(f1, rnd_vec(100));
      send_vec(f1 ^ rnd_vec(30), rnd_vec(100));
      drain_and_idle(feature_in);
    end

    // Reset while the second of three groups is presented
    ids = '{0, 5, 10, 15, 20, 25, 30, 35, 40, 45, 50, 55};
    f1 = vec_at(ids, 7);
    send_vec(f1, rnd_vec(100));
    for (int n = 0; n < 20 && sb.size() > 2; n++) tick();
    tick();
    chk("pre_reset_group2", FW'(sb.size()), FW'(1));
    reset = 1'b1;
    sb.delete();
    tick();
    chk("abort_vd", FW'(issue_vd), FW'(0));
    chk("abort_ready", FW'(in_ready), FW'(1));
    chk("abort_busy", FW'(busy), FW'(0));
    reset = 1'b0;
    tick();
    tick();
    chk("abort_no_more", FW'(issue_vd), FW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
